button_reader: RTL and testbench
================================

# button_reader

Debounced push-button input block: the input-side counterpart to the board's LED output drivers. It takes one raw, asynchronous, bouncing button pin, synchronizes and debounces it, and presents a clean level, single-cycle press/release/long-press pulses, and a press-toggled level that can drive an LED directly. It sits between a board switch pin (icestick PMOD button, Alhambra SW1/SW2) and user logic.

## Interface
- DEBOUNCE_CYCLES, 120000: consecutive stable samples required to accept a level change. This is 10 ms at 12 MHz. Must be >= 1.
- LONG_CYCLES, 12000000: cycles in PRESSED before LONG fires. This is 1 s at 12 MHz. A value of 0 disables LONG.
- ACTIVE_LEVEL, 1: raw BTN level that means "pressed". Use 0 for pull-up buttons.
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- BTN  in  1  raw button pin; asynchronous, may bounce.
- BTN_STATE  out  1  debounced level, 1 = pressed.
- PRESS  out  1  one-cycle pulse on accepted press.
- RELEASE  out  1  one-cycle pulse on accepted release.
- LONG  out  1  one-cycle pulse, at most once per press.
- TOGGLE  out  1  inverts on every PRESS pulse.

## Operation
- Sync: BTN passes through 2 flops, then is normalized to btn_s (1 = pressed when BTN == ACTIVE_LEVEL). Both flops reset to the not-pressed value.
- Debounce counter: $clog2(DEBOUNCE_CYCLES+1) bits. Hold counter: $clog2(LONG_CYCLES+1) bits, with a minimum of 1 bit. Neither counter wraps.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE:
  - btn_s=1 -> PRESS_WAIT, debounce counter cleared to 0.
  - Otherwise stay.
- PRESS_WAIT:
  - btn_s=0 -> IDLE. This is a bounce: no pulse, counter cleared.
  - btn_s=1 and counter == DEBOUNCE_CYCLES-1 -> PRESSED. Assert PRESS for one cycle, set BTN_STATE=1, invert TOGGLE, clear the hold counter.
  - Otherwise increment the counter.
- PRESSED:
  - btn_s=0 -> RELEASE_WAIT, debounce counter cleared.
  - Otherwise the hold counter increments and saturates at LONG_CYCLES.
  - When LONG_CYCLES != 0 and the counter reaches LONG_CYCLES-1, assert LONG for one cycle. Saturation guarantees LONG cannot repeat.
- RELEASE_WAIT:
  - btn_s=1 -> PRESSED. The hold counter is frozen here and resumes, not cleared. No pulse.
  - btn_s=0 and counter == DEBOUNCE_CYCLES-1 -> IDLE. Assert RELEASE for one cycle, set BTN_STATE=0.
  - Otherwise increment.
- BTN_STATE stays 1 throughout RELEASE_WAIT and 0 throughout PRESS_WAIT. Only accepted transitions change it.
- LONG and RELEASE never coincide: LONG is only emitted in PRESSED, RELEASE only on exit from RELEASE_WAIT.
- A button held across reset deassertion goes through the normal debounce and produces a PRESS.

## Timing
- Reset values: BTN_STATE=0, PRESS=0, RELEASE=0, LONG=0, TOGGLE=0, FSM=IDLE, both counters 0.
- All outputs are registered. There is no combinational path from BTN to any output.
- Press latency: let edge 0 be the first CLK edge that samples BTN at the pressed level, held stable afterwards.
  - btn_s is valid after edge 1.
  - IDLE -> PRESS_WAIT at edge 2.
  - PRESS and BTN_STATE rise at edge DEBOUNCE_CYCLES+2.
- Release latency is identical and measured to the RELEASE edge.
- LONG rises LONG_CYCLES edges after PRESS rises, provided there are no release glitches. Cycles spent in RELEASE_WAIT are not counted.
- Pulses are exactly 1 cycle wide. TOGGLE changes on the same edge that PRESS rises.
- Reset asserted mid-operation: on RST_N low, all state and outputs clear immediately (asynchronous). No pulse is emitted after reset releases unless a new debounce completes.
- Minimum press/release spacing is DEBOUNCE_CYCLES+1 cycles per edge. Faster toggling is filtered out as bounce.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LEVEL=1.
- Clean press/release:
  - Raise BTN before edge 0 -> PRESS=1 and BTN_STATE=1 after edge 6, TOGGLE 0->1.
  - Drop BTN 30 cycles later -> RELEASE pulse 6 edges after the drop sample, BTN_STATE=0.
- Bounce rejection:
  - BTN pattern 1,1,0,1,0,1,1,1,1,1,1 (one sample per edge) -> exactly one PRESS, rising 6 edges after the final 0->1 sample. No PRESS earlier.
- Long press:
  - Hold BTN for 40 cycles -> LONG single pulse exactly 20 edges after the PRESS edge.
  - LONG does not repeat.
  - RELEASE follows after the release latency.
- Release glitch while held:
  - In PRESSED, drop BTN for 2 cycles, then restore -> no RELEASE, BTN_STATE stays 1.
  - LONG is delayed by the cycles spent in RELEASE_WAIT.
- Reset mid-operation:
  - Assert RST_N=0 while in PRESS_WAIT and again while in PRESSED -> all outputs 0 immediately.
  - With BTN held through the reset release, PRESS fires 6 edges after the first post-reset sample and TOGGLE goes to 1.
- ACTIVE_LEVEL=0 variant:
  - Idle BTN=1 -> no pulses.
  - Drive BTN=0 -> PRESS after 6 edges, the same behaviour as the active-high case.

Source files
------------

// File: rtl/button_reader.sv
// button_reader: synchronizes and debounces one raw button pin.
// Emits a clean level, press/release/long pulses and a press toggle.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter bit ACTIVE_LEVEL    = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic BTN_STATE,
  output logic PRESS,
  output logic RELEASE,
  output logic LONG,
  output logic TOGGLE
);

  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW0 = $clog2(LONG_CYCLES + 1);
  localparam int HW  = (HW0 < 1) ? 1 : HW0;

  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HLAST = HW'(LONG_CYCLES - 1);
  localparam bit            LONG_EN = (LONG_CYCLES != 0);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic          s1;
  logic          s2;
  logic          btn_s;
  logic [1:0]    state;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;

  assign btn_s = (s2 == ACTIVE_LEVEL);

  // Two-flop synchronizer; idles at the not-pressed pin level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= ~ACTIVE_LEVEL;
      s2 <= ~ACTIVE_LEVEL;
    end else begin
      s1 <= BTN;
      s2 <= s1;
    end
  end

  // Debounce FSM with registered level, pulses and toggle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      dcnt      <= '0;
      hcnt      <= '0;
      BTN_STATE <= 1'b0;
      PRESS     <= 1'b0;
      RELEASE   <= 1'b0;
      LONG      <= 1'b0;
      TOGGLE    <= 1'b0;
    end else begin
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
      LONG    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (dcnt == DLAST) begin
            state     <= PRESSED;
            PRESS     <= 1'b1;
            BTN_STATE <= 1'b1;
            TOGGLE    <= ~TOGGLE;
            hcnt      <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end else begin
            if (hcnt != HMAX) hcnt <= hcnt + 1'b1;
            if (LONG_EN && hcnt == HLAST) LONG <= 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= PRESSED;
          end else if (dcnt == DLAST) begin
            state     <= IDLE;
            RELEASE   <= 1'b1;
            BTN_STATE <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: directed stimulus with an event scoreboard.
// Unit 0 is active-high, unit 1 is active-low.
module tb_button_reader;

  localparam int D   = 4;
  localparam int L   = 20;
  localparam int LAT = D + 3;

  typedef struct {
    int   k;
    int   at;
    logic t;
    logic s;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       btn_n = 1'b1;
  logic [1:0] st;
  logic [1:0] pr;
  logic [1:0] rl;
  logic [1:0] lg;
  logic [1:0] tg;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  ev_t        q0[$];
  ev_t        q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_reader #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .ACTIVE_LEVEL(1'b1)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .BTN(btn),
    .BTN_STATE(st[0]),
    .PRESS(pr[0]),
    .RELEASE(rl[0]),
    .LONG(lg[0]),
    .TOGGLE(tg[0])
  );

  button_reader #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .ACTIVE_LEVEL(1'b0)
  ) dut_n (
    .CLK(clk),
    .RST_N(rst_n),
    .BTN(btn_n),
    .BTN_STATE(st[1]),
    .PRESS(pr[1]),
    .RELEASE(rl[1]),
    .LONG(lg[1]),
    .TOGGLE(tg[1])
  );

  function automatic ev_t mk(int k, int at, logic t, logic s);
    ev_t e;
    e.k  = k;
    e.at = at;
    e.t  = t;
    e.s  = s;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at cyc %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string nm);
    #1;
    check({nm, "_u0"}, int'({st[0], pr[0], rl[0], lg[0], tg[0]}), 0);
    check({nm, "_u1"}, int'({st[1], pr[1], rl[1], lg[1], tg[1]}), 0);
  endtask

  // kind: 0 press, 1 release, 2 long
  task automatic mon(input int u);
    ev_t e;
    int  k;
    int  n;
    n = int'(pr[u]) + int'(rl[u]) + int'(lg[u]);
    if (n == 0) return;
    k = pr[u] ? 0 : (rl[u] ? 1 : 2);
    checks++;
    if (u == 0 && q0.size() > 0) begin
      e = q0.pop_front();
    end else if (u == 1 && q1.size() > 0) begin
      e = q1.pop_front();
    end else begin
      errors++;
      $display("FAIL u%0d unexpected pulse: kind=%0d cyc=%0d", u, k, cyc);
      return;
    end
    if (n != 1 || e.k != k || e.at != cyc ||
        e.t !== tg[u] || e.s !== st[u]) begin
      errors++;
      $display("FAIL u%0d event: got kind=%0d n=%0d cyc=%0d tog=%b st=%b want kind=%0d cyc=%0d tog=%b st=%b",
               u, k, n, cyc, tg[u], st[u], e.k, e.at, e.t, e.s);
    end
  endtask

  initial begin
    int   c;
    logic pat [11];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    fork
      forever begin
        @(negedge clk);
        mon(0);
        mon(1);
      end
    join_none

    tick(2);
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);

    // clean press, held 30 cycles so LONG fires too
    c = cyc;
    btn = 1'b1;
    q0.push_back(mk(0, c + LAT, 1'b1, 1'b1));
    q0.push_back(mk(2, c + LAT + L, 1'b1, 1'b1));
    tick(30);
    c = cyc;
    btn = 1'b0;
    q0.push_back(mk(1, c + LAT, 1'b1, 1'b0));
    tick(12);

    // bounce: last 0->1 sample lands on edge c+6
    c = cyc;
    q0.push_back(mk(0, c + 12, 1'b0, 1'b1));
    for (int i = 0; i < 11; i++) begin
      btn = pat[i];
      tick(1);
    end
    c = cyc;
    btn = 1'b0;
    q0.push_back(mk(1, c + LAT, 1'b0, 1'b0));
    tick(12);

    // long press, 40 cycles
    c = cyc;
    btn = 1'b1;
    q0.push_back(mk(0, c + LAT, 1'b1, 1'b1));
    q0.push_back(mk(2, c + LAT + L, 1'b1, 1'b1));
    tick(40);
    c = cyc;
    btn = 1'b0;
    q0.push_back(mk(1, c + LAT, 1'b1, 1'b0));
    tick(12);

    // 2-sample release glitch: 3 edges without hold counting
    c = cyc;
    btn = 1'b1;
    q0.push_back(mk(0, c + LAT, 1'b0, 1'b1));
    q0.push_back(mk(2, c + LAT + L + 3, 1'b0, 1'b1));
    tick(10);
    btn = 1'b0;
    tick(2);
    btn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("glitch_state", int'(st[0]), 1);
      tick(1);
    end
    tick(24);
    c = cyc;
    btn = 1'b0;
    q0.push_back(mk(1, c + LAT, 1'b0, 1'b0));
    tick(12);

    // reset in PRESS_WAIT, then in PRESSED, button held
    btn = 1'b1;
    tick(4);
    rst_n = 1'b0;
    chk_zero("rst_pw");
    tick(2);
    rst_n = 1'b1;
    c = cyc;
    q0.push_back(mk(0, c + LAT, 1'b1, 1'b1));
    tick(10);
    rst_n = 1'b0;
    chk_zero("rst_pressed");
    tick(2);
    rst_n = 1'b1;
    c = cyc;
    q0.push_back(mk(0, c + LAT, 1'b1, 1'b1));
    tick(10);
    c = cyc;
    btn = 1'b0;
    q0.push_back(mk(1, c + LAT, 1'b1, 1'b0));
    tick(12);

    // active-low unit
    c = cyc;
    btn_n = 1'b0;
    q1.push_back(mk(0, c + LAT, 1'b1, 1'b1));
    tick(10);
    c = cyc;
    btn_n = 1'b1;
    q1.push_back(mk(1, c + LAT, 1'b1, 1'b0));
    tick(12);

    check("q0_left", q0.size(), 0);
    check("q1_left", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
